stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Round-robin controller that shares one `stack` instance between two requesters.
- Each requester issues single push or pop transactions with a req/done handshake.
- The arbiter serialises the transactions and drives the stack strobes. It returns pop data and flags overflow/underflow per transaction.
- It sits between client logic and the stack; the stack keeps its own storage and full/empty logic.

Parameters:
DATA_WIDTH, 4, width of stack words and client data
N_CLIENTS, 2, number of requesters (fixed at 2; parameter exists for port sizing only)

Ports:
clk_i  input  1  system clock, rising edge
reset_ni  input  1  asynchronous active-low reset
req_i  input  2  per-client request; bit k = client k
op_i  input  2  per-client operation; 0 = push, 1 = pop
wdata_i  input  2*DATA_WIDTH  per-client push data; client k at bits [k*DATA_WIDTH +: DATA_WIDTH]
gnt_o  output  2  one-hot grant, high during EXEC and DONE of the granted client
done_o  output  2  one-cycle completion pulse to the granted client
err_o  output  1  valid with done_o; 1 = push while full or pop while empty, stack untouched
rdata_o  output  DATA_WIDTH  popped word, valid with done_o on a successful pop; holds its last value otherwise
push_o  output  1  push strobe to stack
pop_o  output  1  pop strobe to stack
write_data_o  output  DATA_WIDTH  data to stack
empty_i  input  1  stack empty flag
full_i  input  1  stack full flag
read_data_i  input  DATA_WIDTH  stack top-of-stack word, valid when not empty

Behaviour:
- Reset (async, reset_ni low), all registers clear immediately:
  - state = IDLE; gnt_o, done_o, err_o, push_o, pop_o = 0.
  - rdata_o = 0, write_data_o = 0.
  - last-grant pointer = 1, so client 0 wins the first contention.
- Stack contract: push/pop take effect at the rising edge where the strobe is high. read_data_i shows top-of-stack combinationally.
- FSM states IDLE, EXEC, DONE; one transaction takes exactly 3 cycles.
- IDLE:
  - If no req_i bit is set, remain in IDLE.
  - If exactly one bit is set, grant that client.
  - If both are set, grant the client not equal to the last-grant pointer.
  - On grant: latch the client id, op and wdata into registers, update the last-grant pointer, go to EXEC.
- EXEC (one cycle): gnt_o is one-hot for the latched id, and write_data_o = latched wdata.
  - Push and full_i = 0: push_o = 1.
  - Pop and empty_i = 0: pop_o = 1, and read_data_i is captured into rdata_o at the closing edge.
  - Push with full_i = 1, or pop with empty_i = 1: no strobe; set the error flag.
  - Go to DONE.
- DONE (one cycle):
  - done_o[id] = 1, err_o = error flag, gnt_o held.
  - Error flag clears on exit. Go to IDLE.
- Strobes are decoded from registered state/op/flags only. push_o and pop_o are never high together and never high outside EXEC.
- Latency: req sampled at IDLE edge t → strobe during cycle t+1 → done_o during cycle t+2 → next IDLE at t+3.
  - Peak throughput: one transaction per 3 cycles.
- Client rules:
  - Hold req_i, op_i and wdata_i stable from assertion until done_o.
  - req_i still high in the cycle after done_o is a new transaction.
  - op_i and wdata_i are ignored after latching.
  - A req dropped before grant is a protocol violation; behaviour is undefined.
- Fairness:
  - With both clients requesting continuously, grants alternate 0,1,0,1.
  - A lone requester is granted back-to-back regardless of the pointer.
- Error transactions still update the last-grant pointer, and still take 3 cycles.
- Reset mid-transaction (EXEC or DONE):
  - Strobes drop asynchronously and no done_o is issued.
  - The stack is reset by the same reset_ni, so no partial state persists.

Test Plan:
- Reset, then client 0 pushes 1 → push_o high exactly one cycle with write_data_o = 1; done_o = 01 two cycles after req sampled; err_o = 0.
- Clients 0 and 1 request push 5 and push 9 on the same cycle, after reset → client 0 granted first; pops then return rdata_o = 9 then 5 (LIFO).
- Both clients hold req high for 6 transactions (pushes of 1..6) → gnt_o sequence 01,10,01,10,01,10; every transaction spaced exactly 3 cycles.
- Pop on empty stack → err_o = 1 with done_o, pop_o never asserted, rdata_o unchanged.
- Stack depth 16 (ADDR_WIDTH = 4): 16 pushes succeed → 17th push returns err_o = 1, push_o stays low, full_i stays 1; next pop returns the 16th word.
- Assert reset_ni low during EXEC of a push → push_o falls immediately, no done_o; after release, state IDLE and client 0 wins the next contention.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter
// -------------
// Round-robin controller that shares one stack between two requesters.
// Each client issues one push or pop at a time over a req/done handshake.
// The arbiter serialises these transactions and drives the stack strobes.
// It returns pop data and flags overflow/underflow per transaction.
//
// Handshake: a client raises req_i[k] with op_i[k]/wdata_i[k] and holds
// all three stable until it sees done_o[k]. The request is sampled at an
// IDLE clock edge. The stack strobe fires in the next cycle (EXEC).
// done_o[k] pulses for one cycle after that (DONE). If req_i[k] is still
// high in the cycle after done_o[k], that is a new transaction.
//
// Ports:
//   clk_i, reset_ni        clock (rising edge), async active-low reset
//   req_i, op_i, wdata_i   per-client request, op (0 push / 1 pop), data
//   gnt_o, done_o, err_o   per-client grant, completion pulse, error flag
//   rdata_o                last successfully popped word
//   push_o, pop_o          stack strobes
//   write_data_o           data presented to the stack
//   empty_i, full_i        stack flags
//   read_data_i            stack top-of-stack word
//
// The FSM state is kept in state_q, which uses the enum type state_t.
module stack_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int N_CLIENTS  = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [N_CLIENTS-1:0]            req_i,
    input  logic [N_CLIENTS-1:0]            op_i,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] wdata_i,
    output logic [N_CLIENTS-1:0]            gnt_o,
    output logic [N_CLIENTS-1:0]            done_o,
    output logic                            err_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            push_o,
    output logic                            pop_o,
    output logic [DATA_WIDTH-1:0]           write_data_o,
    input  logic                            empty_i,
    input  logic                            full_i,
    input  logic [DATA_WIDTH-1:0]           read_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    id_q;      // latched client id
    logic                    op_q;      // latched op, 1 = pop
    logic [DATA_WIDTH-1:0]   wdata_q;   // latched push data
    logic                    last_q;    // client granted most recently
    logic                    err_q;     // error of the current transaction
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    grant_id;
    logic [DATA_WIDTH-1:0]   grant_wdata;
    logic                    exec_err;

    // Under contention, grant the client that did not win last time.
    // A lone requester wins no matter what the pointer says.
    always_comb begin
        if (&req_i) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req_i[1];
        end
        grant_wdata = grant_id ? wdata_i[DATA_WIDTH +: DATA_WIDTH]
                               : wdata_i[0 +: DATA_WIDTH];
    end

    assign exec_err = (state_q == EXEC) && (op_q ? empty_i : full_i);

    // Outputs are decoded only from registered state, the latched op and
    // the stack flags. An async reset of state_q therefore drops strobes
    // at once.
    always_comb begin
        state_d = state_q;
        gnt_o   = '0;
        done_o  = '0;
        err_o   = 1'b0;
        push_o  = 1'b0;
        pop_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt_o[id_q] = 1'b1;
                push_o      = !op_q && !full_i;
                pop_o       = op_q && !empty_i;
                state_d     = DONE;
            end
            DONE: begin
                gnt_o[id_q]  = 1'b1;
                done_o[id_q] = 1'b1;
                err_o        = err_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            last_q  <= 1'b1;   // client 0 wins the first contention
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_i) begin
                id_q    <= grant_id;
                op_q    <= op_i[grant_id];
                wdata_q <= grant_wdata;
                last_q  <= grant_id;
            end
            if (state_q == EXEC) begin
                err_q <= exec_err;
                if (pop_o) begin
                    rdata_q <= read_data_i;
                end
            end
            if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    assign write_data_o = wdata_q;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    localparam int DW    = 4;
    localparam int DEPTH = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT connections
    logic [1:0]    req;
    logic [1:0]    op;
    logic [2*DW-1:0] wdata;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          push;
    logic          pop;
    logic [DW-1:0] write_data;
    logic          empty;
    logic          full;
    logic [DW-1:0] read_data;

    stack_arbiter #(.DATA_WIDTH(DW), .N_CLIENTS(2)) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .req_i        (req),
        .op_i         (op),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .done_o       (done),
        .err_o        (err),
        .rdata_o      (rdata),
        .push_o       (push),
        .pop_o        (pop),
        .write_data_o (write_data),
        .empty_i      (empty),
        .full_i       (full),
        .read_data_i  (read_data)
    );

    // behavioural stack, depth 16, reset by the same reset
    logic [DW-1:0] mem [DEPTH];
    logic [4:0]    sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && sp != 5'(DEPTH)) begin
            mem[sp[3:0]] <= write_data;
            sp <= sp + 5'd1;
        end else if (pop && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end

    assign empty     = (sp == 5'd0);
    assign full      = (sp == 5'(DEPTH));
    assign read_data = empty ? '0 : mem[sp[3:0] - 4'd1];

    // scoreboard counters
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step to the next falling edge (one full cycle later).
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One single-client transaction, started at a falling edge in IDLE.
    // Checks the EXEC and DONE cycles and the return to IDLE.
    task automatic single_txn(input int c, input logic o, input logic [DW-1:0] d,
                              input logic exp_err, input logic [DW-1:0] exp_rd,
                              input string tag);
        logic [1:0] oh;
        oh = (c == 0) ? 2'b01 : 2'b10;
        req[c] = 1'b1;
        op[c]  = o;
        wdata[c*DW +: DW] = d;
        cyc();  // EXEC
        check({tag, ".exec_gnt"},  gnt,  oh);
        check({tag, ".exec_push"}, push, (!o && !exp_err));
        check({tag, ".exec_pop"},  pop,  (o && !exp_err));
        if (!o) check({tag, ".wdata"}, write_data, d);
        cyc();  // DONE
        check({tag, ".done"},      done, oh);
        check({tag, ".err"},       err,  exp_err);
        check({tag, ".done_strb"}, {push, pop}, 2'b00);
        check({tag, ".rdata"},     rdata, exp_rd);
        req[c] = 1'b0;
        cyc();  // IDLE
        check({tag, ".idle_gnt"},  {gnt, done}, 4'b0000);
    endtask

    initial begin
        req   = '0;
        op    = '0;
        wdata = '0;

        // ---- reset state
        apply_reset();
        check("rst.gnt",   gnt,   2'b00);
        check("rst.done",  done,  2'b00);
        check("rst.err",   err,   1'b0);
        check("rst.push",  push,  1'b0);
        check("rst.pop",   pop,   1'b0);
        check("rst.rdata", rdata, 4'h0);
        check("rst.wdata", write_data, 4'h0);

        // ---- client 0 push 1, client 1 pops it back, then pop on empty
        single_txn(0, 1'b0, 4'h1, 1'b0, 4'h0, "push1");
        single_txn(1, 1'b1, 4'h0, 1'b0, 4'h1, "pop1");
        single_txn(0, 1'b1, 4'h0, 1'b1, 4'h1, "pop_empty");

        // ---- simultaneous push 5 (c0) / push 9 (c1) after reset
        apply_reset();
        req   = 2'b11;
        op    = 2'b00;
        wdata = {4'h9, 4'h5};
        cyc();
        check("cont.gnt0",  gnt, 2'b01);
        check("cont.wd0",   write_data, 4'h5);
        cyc();
        check("cont.done0", done, 2'b01);
        req[0] = 1'b0;
        cyc();
        check("cont.idle",  gnt, 2'b00);
        cyc();
        check("cont.gnt1",  gnt, 2'b10);
        check("cont.wd1",   write_data, 4'h9);
        cyc();
        check("cont.done1", done, 2'b10);
        req[1] = 1'b0;
        cyc();
        single_txn(0, 1'b1, 4'h0, 1'b0, 4'h9, "lifo_a");
        single_txn(1, 1'b1, 4'h0, 1'b0, 4'h5, "lifo_b");

        // ---- both clients request continuously: pushes 1..6 alternate
        apply_reset();
        op    = 2'b00;
        wdata = {4'h2, 4'h1};
        req   = 2'b11;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] oh;
            int c;
            c  = i % 2;
            oh = (c == 0) ? 2'b01 : 2'b10;
            check("rr.idle", {gnt, done}, 4'b0000);
            cyc();
            check("rr.gnt",  gnt, oh);
            check("rr.push", push, 1'b1);
            check("rr.wd",   write_data, 4'(i + 1));
            cyc();
            check("rr.done", done, oh);
            wdata[c*DW +: DW] = 4'(i + 3);
            if (i == 5) req = 2'b00;
            cyc();
        end
        single_txn(1, 1'b1, 4'h0, 1'b0, 4'h6, "rr_pop");

        // ---- fill to depth 16, overflow, then pop the 16th word
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            single_txn(0, 1'b0, 4'(k) ^ 4'ha, 1'b0, 4'h0, "fill");
        end
        check("full.flag", full, 1'b1);
        single_txn(0, 1'b0, 4'h3, 1'b1, 4'h0, "overflow");
        check("full.after_ovf", full, 1'b1);
        single_txn(1, 1'b1, 4'h0, 1'b0, 4'h5, "pop16");  // 15 ^ a = 5

        // ---- reset during EXEC of a push
        apply_reset();
        req[0] = 1'b1;
        op[0]  = 1'b0;
        wdata[0 +: DW] = 4'h7;
        cyc();
        check("mid.push_before", push, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.push_async", push, 1'b0);
        check("mid.gnt_async",  gnt,  2'b00);
        req = 2'b00;
        repeat (2) begin
            @(negedge clk);
            check("mid.no_done", done, 2'b00);
        end
        rst_n = 1'b1;
        check("mid.empty", empty, 1'b1);
        req   = 2'b11;
        op    = 2'b00;
        wdata = {4'hc, 4'hb};
        cyc();
        check("mid.cont_gnt", gnt, 2'b01);
        check("mid.cont_wd",  write_data, 4'hb);
        cyc();
        check("mid.cont_done", done, 2'b01);
        req = 2'b00;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
